mdu_ctrl: RTL
=============

Name: mdu_ctrl

Overview:
- Sequencing controller for the multiply/divide unit in the EX stage of the 5-stage MIPS pipeline.
- Accepts one MDU operation per cycle from EX, runs multi-cycle mult/div with fixed latency, and owns the HI/LO registers.
- Drives Start/Busy to the hazard unit, which stalls MDU-dependent instructions in ID.
- Honours the interrupt flush so a squashed EX instruction never alters HI/LO.

Parameters:
- MULT_CYC, 5, number of Busy cycles for mult/multu (≥1).
- DIV_CYC, 10, number of Busy cycles for div/divu (≥1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYC, DIV_CYC).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Op  in  4  EX-stage MDU op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9–15 none.
- A  in  32  forwarded rs value.
- B  in  32  forwarded rt value.
- Flush  in  1  interrupt/exception flush (IntReq); kills the Op presented this cycle.
- Start  out  1  combinational: legal op 1–4 presented this cycle.
- Busy  out  1  registered: a mult/div is in flight.
- hi  out  32  HI register, registered.
- lo  out  32  LO register, registered.
- Drop  out  1  registered, one-cycle pulse: an op was discarded because Busy was high (hazard-unit violation flag, verification only).

Behaviour:
- Reset (async):
  - State IDLE, counter 0.
  - Busy=0, Drop=0, hi=0, lo=0.
  - Pending result registers cleared.
- Start = (Op in 1..4) & ~Flush & ~Busy.
- mfhi/mflo (5/6) do not alter state; EX reads hi/lo directly.
  - Valid in the same cycle when Busy=0.
  - The hazard unit must never present them while Busy=1.
- mthi/mtlo (7/8), Busy=0, Flush=0: hi (resp. lo) ← A at the next edge. No Busy.
- States: IDLE, MUL, DIV.
- IDLE → MUL on Start with Op 1/2. At the same edge:
  - Pending {hi,lo} ← 64-bit product: signed for 1, unsigned for 2.
  - Counter ← MULT_CYC−1, Busy ← 1.
- IDLE → DIV on Start with Op 3/4. At the same edge:
  - Pending lo ← quotient, pending hi ← remainder. Signed for 3: truncate toward zero, remainder takes the dividend's sign. Unsigned for 4.
  - Counter ← DIV_CYC−1, Busy ← 1.
- Divide by zero (B=0): pending hi ← A, pending lo ← 32'hFFFF_FFFF. No exception.
- Signed overflow (A=32'h8000_0000, B=32'hFFFF_FFFF): lo ← 32'h8000_0000, hi ← 0.
- MUL/DIV, counter≠0: counter decrements, Busy stays 1, hi/lo unchanged.
- MUL/DIV, counter=0: at the edge, hi/lo ← pending, Busy ← 0, state → IDLE.
  - Busy is high for exactly MULT_CYC / DIV_CYC cycles after the issue edge.
  - New hi/lo are visible the first cycle Busy=0.
- Back-to-back: a new Start is accepted the first cycle Busy=0 (the cycle after commit).
- Flush:
  - Suppresses the Op of the current cycle only: no Start, no mthi/mtlo write, no Drop.
  - An operation already in flight completes and commits; it belongs to an older, committed instruction.
- Any op 1–4 or 7–8 presented while Busy=1 with Flush=0:
  - Ignored, and Drop pulses for one cycle.
  - The in-flight operation continues unaffected.
- Reset mid-operation: aborts immediately to the reset values. The pending result is lost.

Decomposition:
- Package mdu_pkg holds:
  - the Op code constants (OP_NONE … OP_MTLO);
  - the state enum {IDLE, MUL, DIV};
  - the default latency constants.
- One natural sub-module, mdu_arith: purely combinational signed/unsigned 64-bit product, quotient/remainder and the divide-by-zero rule.
- mdu_ctrl keeps the FSM, counter and HI/LO/pending registers.

Test Plan:
- Reset mid-DIV (assert at Busy cycle 4) → Busy=0, hi=lo=0 immediately; next Op=1 accepted normally.
- Op=1, A=−3 (32'hFFFF_FFFD), B=7, then Op=0 → Busy high exactly 5 cycles; then hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB.
- Op=4, A=100, B=7 → Busy high 10 cycles; then lo=14, hi=2.
- Op=3, A=−7, B=2 → lo=32'hFFFF_FFFD (−3), hi=32'hFFFF_FFFF (−1).
- Op=3, A=5, B=0 → lo=32'hFFFF_FFFF, hi=5.
- Op=2 with Flush=1 → Start=0, Busy stays 0, hi/lo unchanged.
- Op=2 at cycle 0, then Op=8 (A=9) at cycle 2 while Busy → Drop pulses at cycle 3; lo after commit equals the product's low word, not 9.
- Op=7 (A=32'h1234_5678) then Op=5 next cycle → hi=32'h1234_5678, Busy never asserted.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes, FSM states
// and default latencies.
package mdu_pkg;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MULT_CYC_DEF = 5;
    localparam int DIV_CYC_DEF  = 10;
    localparam int CNT_W_DEF    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_e;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// EX-stage <-> MDU connection: op/operands/flush in, handshake and HI/LO out.
interface mdu_ctrl_if;
    logic [3:0]  Op;
    logic [31:0] A;
    logic [31:0] B;
    logic        Flush;
    logic        Start;
    logic        Busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        Drop;

    modport master (
        output Op, A, B, Flush,
        input  Start, Busy, hi, lo, Drop
    );

    modport slave (
        input  Op, A, B, Flush,
        output Start, Busy, hi, lo, Drop
    );
endinterface

// File: rtl/mdu_arith.sv
// Combinational datapath: 64-bit product plus quotient/remainder, signed or
// unsigned, with the MIPS divide-by-zero result convention.
module mdu_arith (
    input  logic        i_signed,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [63:0] o_prod,
    output logic [31:0] o_quot,
    output logic [31:0] o_rem
);
    logic        w_a_neg;
    logic        w_b_neg;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;

    // Sign-magnitude division keeps 0x8000_0000 / -1 well defined (wraps to 0x8000_0000).
    always_comb begin
        w_a_neg = i_signed & i_a[31];
        w_b_neg = i_signed & i_b[31];
        w_a_ext = {{32{w_a_neg}}, i_a};
        w_b_ext = {{32{w_b_neg}}, i_b};
        o_prod  = w_a_ext * w_b_ext;
        w_a_mag = w_a_neg ? (32'd0 - i_a) : i_a;
        w_b_mag = w_b_neg ? (32'd0 - i_b) : i_b;
        if (i_b == 32'd0) begin
            w_q_mag = 32'd0;
            w_r_mag = 32'd0;
            o_quot  = 32'hFFFF_FFFF;
            o_rem   = i_a;
        end else begin
            w_q_mag = w_a_mag / w_b_mag;
            w_r_mag = w_a_mag % w_b_mag;
            o_quot  = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
            o_rem   = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;
        end
    end
endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer: issues fixed-latency mult/div, owns HI/LO, reports Busy/Drop
// to the hazard unit and ignores flushed ops.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYC = MULT_CYC_DEF,
    parameter int DIV_CYC  = DIV_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);
    mdu_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_drop;
    logic [31:0]       r_hi;
    logic [31:0]       r_lo;
    logic [31:0]       r_phi;
    logic [31:0]       r_plo;

    logic              w_live;
    logic              w_is_mul;
    logic              w_is_div;
    logic              w_is_mt;
    logic              w_start;
    logic              w_drop;
    logic [63:0]       w_prod;
    logic [31:0]       w_quot;
    logic [31:0]       w_rem;

    mdu_arith u_arith (
        .i_signed (is_signed_op(bus.Op)),
        .i_a      (bus.A),
        .i_b      (bus.B),
        .o_prod   (w_prod),
        .o_quot   (w_quot),
        .o_rem    (w_rem)
    );

    // Decode the EX op; a live op is neither flushed nor blocked by an in-flight one.
    always_comb begin
        w_live   = ~bus.Flush & ~r_busy;
        w_is_mul = (bus.Op == OP_MULT) || (bus.Op == OP_MULTU);
        w_is_div = (bus.Op == OP_DIV) || (bus.Op == OP_DIVU);
        w_is_mt  = (bus.Op == OP_MTHI) || (bus.Op == OP_MTLO);
        w_start  = is_muldiv(bus.Op) & w_live;
        w_drop   = r_busy & ~bus.Flush & (is_muldiv(bus.Op) | w_is_mt);
    end

    // FSM, latency counter, pending result and architectural HI/LO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_busy  <= 1'b0;
            r_drop  <= 1'b0;
            r_hi    <= 32'd0;
            r_lo    <= 32'd0;
            r_phi   <= 32'd0;
            r_plo   <= 32'd0;
        end else begin
            r_drop <= w_drop;
            case (r_state)
                IDLE: begin
                    if (w_start && w_is_mul) begin
                        r_state        <= MUL;
                        {r_phi, r_plo} <= w_prod;
                        r_cnt          <= CNT_W'(MULT_CYC - 1);
                        r_busy         <= 1'b1;
                    end else if (w_start && w_is_div) begin
                        r_state <= DIV;
                        r_phi   <= w_rem;
                        r_plo   <= w_quot;
                        r_cnt   <= CNT_W'(DIV_CYC - 1);
                        r_busy  <= 1'b1;
                    end else if (w_live && (bus.Op == OP_MTHI)) begin
                        r_hi <= bus.A;
                    end else if (w_live && (bus.Op == OP_MTLO)) begin
                        r_lo <= bus.A;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                MUL, DIV: begin
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_hi    <= r_phi;
                        r_lo    <= r_plo;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Start = w_start;
    assign bus.Busy  = r_busy;
    assign bus.hi    = r_hi;
    assign bus.lo    = r_lo;
    assign bus.Drop  = r_drop;
endmodule
